// File: rtl/vga_frame_checker.sv
// vga_frame_checker: rebuilds active-pixel coordinates from VGA sync/blank inputs,
// checks per-frame active geometry and accumulates a rotating per-frame pixel signature.
module vga_frame_checker #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_n_in,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic        pix_valid,
    output logic [9:0]  x_out,
    output logic [9:0]  y_out,
    output logic        frame_done,
    output logic [31:0] frame_sig,
    output logic [9:0]  active_lines,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic        locked
);
    typedef enum logic {ACQUIRE, RUN} state_t;

    localparam logic [9:0] HA = 10'(H_ACTIVE);
    localparam logic [9:0] VA = 10'(V_ACTIVE);
    localparam logic [2:0] LF = 3'(LOCK_FRAMES);

    state_t      state;
    logic        hs1, vs1, bn1, hs2, vs2, bn2;
    logic [23:0] rgb1;
    logic [9:0]  x_cnt, y_cnt;
    logic [31:0] sig;
    logic        hlen_bad;
    logic [2:0]  lock_cnt;

    logic        vs_fall, bn_fall, hs_fall;
    logic [9:0]  x_inc, y_line;
    logic        hlen_end, vlen_end;
    logic [2:0]  lock_nxt;
    logic [31:0] sig_nxt;

    // Line-end results are folded in before the frame latch so a coincident
    // blank_n/vs fall still counts the last line into the ending frame.
    always_comb begin
        vs_fall  = vs2 & ~vs1;
        bn_fall  = bn2 & ~bn1;
        hs_fall  = hs2 & ~hs1;
        x_inc    = (x_cnt == 10'h3ff) ? x_cnt : x_cnt + 10'd1;
        y_line   = bn_fall ? ((y_cnt == 10'h3ff) ? y_cnt : y_cnt + 10'd1) : y_cnt;
        hlen_end = hlen_bad | (bn_fall && x_cnt != HA);
        vlen_end = y_line != VA;
        lock_nxt = (hlen_end | vlen_end) ? 3'd0 : ((lock_cnt == 3'd7) ? lock_cnt : lock_cnt + 3'd1);
        sig_nxt  = {sig[30:0], sig[31]} ^ {8'h00, rgb1};
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state        <= ACQUIRE;
            hs1          <= 1'b0;
            vs1          <= 1'b0;
            bn1          <= 1'b0;
            hs2          <= 1'b0;
            vs2          <= 1'b0;
            bn2          <= 1'b0;
            rgb1         <= 24'h0;
            x_cnt        <= 10'd0;
            y_cnt        <= 10'd0;
            sig          <= 32'h0;
            hlen_bad     <= 1'b0;
            lock_cnt     <= 3'd0;
            pix_valid    <= 1'b0;
            x_out        <= 10'd0;
            y_out        <= 10'd0;
            frame_done   <= 1'b0;
            frame_sig    <= 32'h0;
            active_lines <= 10'd0;
            err_hlen     <= 1'b0;
            err_vlen     <= 1'b0;
            locked       <= 1'b0;
        end else begin
            hs1        <= hs_in;
            vs1        <= vs_in;
            bn1        <= blank_n_in;
            rgb1       <= {r_in, g_in, b_in};
            hs2        <= hs1;
            vs2        <= vs1;
            bn2        <= bn1;
            pix_valid  <= bn1;
            frame_done <= 1'b0;
            if (bn1) begin
                x_out <= x_cnt;
                y_out <= y_cnt;
            end
            if (state == ACQUIRE) begin
                if (vs_fall) begin
                    state    <= RUN;
                    sig      <= 32'h0;
                    x_cnt    <= 10'd0;
                    y_cnt    <= 10'd0;
                    hlen_bad <= 1'b0;
                end
            end else if (vs_fall) begin
                frame_sig    <= sig;
                active_lines <= y_line;
                err_hlen     <= hlen_end;
                err_vlen     <= vlen_end;
                lock_cnt     <= lock_nxt;
                locked       <= lock_nxt >= LF;
                frame_done   <= 1'b1;
                sig          <= 32'h0;
                x_cnt        <= 10'd0;
                y_cnt        <= 10'd0;
                hlen_bad     <= 1'b0;
            end else begin
                if (bn1) begin
                    x_cnt <= x_inc;
                    sig   <= sig_nxt;
                end
                if (bn_fall || hs_fall)
                    x_cnt <= 10'd0;
                if (bn_fall) begin
                    y_cnt    <= y_line;
                    hlen_bad <= hlen_end;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_checker.sv
// tb_vga_frame_checker: directed frames on a reduced 12x7 timing (8x4 active)
// with hand-computed geometry, signature, lock and coordinate expectations.
module tb_vga_frame_checker;
    logic        vga_clk = 1'b0;
    logic        reset;
    logic        hs_in, vs_in, blank_n_in;
    logic [7:0]  r_in, g_in, b_in;
    logic        pix_valid;
    logic [9:0]  x_out, y_out;
    logic        frame_done;
    logic [31:0] frame_sig;
    logic [9:0]  active_lines;
    logic        err_hlen, err_vlen, locked;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    vga_frame_checker #(.H_ACTIVE(8), .V_ACTIVE(4), .LOCK_FRAMES(2)) dut (
        .vga_clk(vga_clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
        .blank_n_in(blank_n_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pix_valid(pix_valid), .x_out(x_out), .y_out(y_out),
        .frame_done(frame_done), .frame_sig(frame_sig), .active_lines(active_lines),
        .err_hlen(err_hlen), .err_vlen(err_vlen), .locked(locked)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) done_cnt <= done_cnt + int'(frame_done);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 12-cycle x 7-line frame: active cols 0-7 on lines 0-3, hs low at cols 9-10,
    // vs low for line 5 (or from the last active line's blank fall when coincide is set).
    task automatic drive_frame(input int short_line, input bit sig_pix, input bit coincide,
                               input bit hs_mid, input bit mid_rst, input bit chk_pix);
        int len;
        for (int l = 0; l < 7; l++) begin
            for (int c = 0; c < 12; c++) begin
                @(posedge vga_clk);
                #1;
                len        = (l == short_line) ? 7 : 8;
                blank_n_in = (l < 4) && (c < len);
                hs_in      = !((c == 9) || (c == 10) || (hs_mid && l == 2 && (c == 2 || c == 3)));
                vs_in      = coincide ? !((l == 3 && c >= 8) || (l == 4 && c < 8)) : (l != 5);
                {r_in, g_in, b_in} = (sig_pix && l == 0 && c == 0) ? 24'h010203 : 24'h0;
                reset      = mid_rst && l == 2 && c >= 4 && c <= 6;
                if (chk_pix && l == 0 && c == 2)
                    chk("first_pix", {pix_valid, x_out, y_out}, {1'b1, 10'd0, 10'd0});
                if (chk_pix && l == 3 && c == 9)
                    chk("last_pix", {pix_valid, x_out, y_out}, {1'b1, 10'd7, 10'd3});
                if (chk_pix && l == 3 && c == 10)
                    chk("blank_hold", {pix_valid, x_out, y_out}, {1'b0, 10'd7, 10'd3});
                if (chk_pix && l == 5 && c == 1)
                    chk("done_early", frame_done, 1'b0);
                if (chk_pix && l == 5 && c == 2)
                    chk("done_edge2", frame_done, 1'b1);
                if (chk_pix && l == 5 && c == 3)
                    chk("done_width", frame_done, 1'b0);
                if (mid_rst && l == 2 && c == 6) begin
                    chk("midrst_sig", frame_sig, 32'h0);
                    chk("midrst_outs", {pix_valid, x_out, y_out, frame_done, active_lines,
                                        err_hlen, err_vlen, locked}, 35'h0);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        hs_in = 1'b1;
        vs_in = 1'b1;
        blank_n_in = 1'b0;
        {r_in, g_in, b_in} = 24'h0;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_sig", frame_sig, 32'h0);
        chk("rst_outs", {pix_valid, x_out, y_out, frame_done, active_lines,
                         err_hlen, err_vlen, locked}, 35'h0);
        reset = 1'b0;

        drive_frame(-1, 0, 0, 0, 0, 0);
        chk("f0_no_done", done_cnt, 0);

        drive_frame(-1, 0, 0, 0, 0, 1);
        chk("f1_done", done_cnt, 1);
        chk("f1_lines", active_lines, 10'd4);
        chk("f1_errs", {err_hlen, err_vlen}, 2'b00);
        chk("f1_sig", frame_sig, 32'h0);
        chk("f1_unlocked", locked, 1'b0);

        drive_frame(-1, 0, 0, 0, 0, 0);
        chk("f2_done", done_cnt, 2);
        chk("f2_locked", locked, 1'b1);

        drive_frame(-1, 1, 0, 0, 0, 0);
        chk("f3_sig", frame_sig, 32'h80008101);
        chk("f3_locked", locked, 1'b1);

        drive_frame(-1, 1, 0, 0, 0, 0);
        chk("f4_sig_repeat", frame_sig, 32'h80008101);

        drive_frame(1, 0, 0, 0, 0, 0);
        chk("f5_short_errs", {err_hlen, err_vlen}, 2'b10);
        chk("f5_short_lines", active_lines, 10'd4);
        chk("f5_unlocked", locked, 1'b0);

        drive_frame(-1, 0, 0, 0, 0, 0);
        chk("f6_clean", {err_hlen, err_vlen, locked}, 3'b000);

        drive_frame(-1, 0, 0, 0, 0, 0);
        chk("f7_relocked", locked, 1'b1);

        drive_frame(-1, 0, 1, 0, 0, 0);
        chk("f8_coincide_lines", active_lines, 10'd4);
        chk("f8_coincide_errs", {err_hlen, err_vlen}, 2'b00);

        drive_frame(-1, 0, 0, 0, 0, 0);
        chk("f9_lines", active_lines, 10'd4);
        chk("f9_done", done_cnt, 9);

        drive_frame(-1, 0, 0, 1, 0, 0);
        chk("f10_hs_clear", {err_hlen, err_vlen, locked}, 3'b100);

        drive_frame(-1, 0, 0, 0, 1, 0);
        chk("f11_no_done", done_cnt, 10);

        drive_frame(-1, 0, 0, 0, 0, 0);
        chk("f12_done", done_cnt, 11);
        chk("f12_lines", active_lines, 10'd4);
        chk("f12_state", {err_hlen, err_vlen, locked}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_frame_checker.md
# vga_frame_checker

Receive-side companion to the VGA timing and pixel generator. It samples the generator's sync, blank and RGB outputs and rebuilds active-pixel x/y coordinates from them. It checks every frame's active geometry against the parameterised mode and produces a per-frame pixel signature. Benches and on-chip self-test use it to confirm that a rendered frame (background, paddles, ball, score) is stable and correctly timed.

## Interface
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive clean frames required to assert locked
- vga_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears every register
- hs_in  in  1  horizontal sync, active-low
- vs_in  in  1  vertical sync, active-low
- blank_n_in  in  1  high during active video
- r_in, g_in, b_in  in  8 each  pixel colour
- pix_valid  out  1  registered copy of blank_n for the current pixel
- x_out  out  10  active-pixel index within the line, 0-based
- y_out  out  10  active-line index within the frame, 0-based
- frame_done  out  1  one-cycle pulse when a frame's results are latched
- frame_sig  out  32  signature of the last completed frame
- active_lines  out  10  active lines counted in the last completed frame
- err_hlen  out  1  last frame had at least one active line with length ≠ H_ACTIVE
- err_vlen  out  1  last frame's active_lines ≠ V_ACTIVE
- locked  out  1  LOCK_FRAMES consecutive clean frames seen

## Operation
- Input stage: all inputs are registered once (stage S1). A second copy of hs, vs and blank_n (S2) is used for edge detection. Edges are detected between S2 and S1.
- Frame state machine: ACQUIRE → RUN.
  - ACQUIRE: counters held at 0, no accumulation, frame_done held low.
  - The first vs falling edge moves ACQUIRE to RUN and clears the accumulators. This edge does not pulse frame_done.
  - RUN: every later vs falling edge ends a frame.
- Pixel tracking in RUN, on each S1 cycle with blank_n = 1:
  - x_cnt increments, saturating at 1023.
  - The signature updates as sig ← {sig[30:0], sig[31]} ^ {8'h00, r, g, b}.
- Line end, on a blank_n falling edge (S2 = 1, S1 = 0):
  - If x_cnt ≠ H_ACTIVE, set the sticky hlen_bad.
  - Increment y_cnt, saturating at 1023.
  - Clear x_cnt.
- An hs falling edge also clears x_cnt. It does not count a line.
- Frame end, on a vs falling edge in RUN:
  - Latch frame_sig ← sig, active_lines ← y_cnt, err_hlen ← hlen_bad, err_vlen ← (y_cnt ≠ V_ACTIVE).
  - Pulse frame_done.
  - Clear sig, x_cnt, y_cnt and hlen_bad.
- Simultaneous blank_n falling and vs falling edges in the same cycle:
  - Line-end processing is applied first, so the line is counted into the ending frame.
  - Then the frame is latched.
- Lock counter (3 bits, saturating):
  - A clean frame (no err_hlen, no err_vlen) increments the counter.
  - An errored frame clears it to 0.
  - locked = (counter ≥ LOCK_FRAMES).
- Coordinate outputs: x_out and y_out present the coordinate of the pixel carried by pix_valid. They hold their last value while pix_valid = 0.
- Reset (asserted at any time, including mid-frame):
  - Every output goes to 0: pix_valid, x_out, y_out, frame_done, frame_sig, active_lines, err_*, locked.
  - State returns to ACQUIRE.
  - After release, no frame_done occurs until the second vs falling edge.

## Timing
- Input-to-output latency: pix_valid, x_out and y_out change 2 rising edges after the corresponding input is presented (S1 register plus output register).
- frame_done: asserted on the 2nd rising edge after vs_in falls, and high for exactly 1 cycle.
- Latched results: frame_sig, active_lines, err_hlen, err_vlen and locked update on the same edge as frame_done and are stable until the next frame_done.
- Throughput: 1 pixel per clock; no stalls and no backpressure.

## Test plan
- Nominal mode: drive a 800×525 timing with 640×480 active and constant RGB 0x000000, then reset and run 3 frames.
  - No frame_done after the first vs fall.
  - Next frame_done: active_lines = 480, err_hlen = 0, err_vlen = 0, frame_sig = 0.
  - locked = 1 after the 2nd frame_done.
- Coordinates: during frame 2, the first active pixel gives x_out = 0, y_out = 0. The last gives x_out = 639, y_out = 479, 2 cycles after presentation.
- Signature: only pixel (0,0) = r 0x01, g 0x02, b 0x03, all others 0 → frame_sig = 0x00010203 rotated left by 307199 mod 32 = 31, i.e. 0x80008101. Frames with identical content must give an identical frame_sig.
- Short line: line 100 has 639 active pixels → that frame has err_hlen = 1 and err_vlen = 0, locked drops to 0, and locked returns to 1 after 2 clean frames.
- Edge coincidence: the last line's blank_n fall coincides with the vs fall → active_lines = 480, not 479.
- Mid-frame reset: assert reset at line 200 for 3 cycles → all outputs 0 and pix_valid low. The first post-reset vs fall produces no frame_done; the next gives active_lines = 480.
